// File: rtl/binary_onehot_decoder.sv
// Registered binary-to-one-hot decoder with octal/decimal/hex range checking and a 2-entry output FIFO.
// Define DEC_ERR_CNT_EN to add the saturating accepted-error counter (err_cnt, width ERR_CNT_W).
module binary_onehot_decoder
`ifdef DEC_ERR_CNT_EN
  #(parameter int ERR_CNT_W = 8)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           bin,
  input  logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          onehot,
  output logic                 out_err
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [1:0]  count;
  logic [15:0] head_oh;
  logic        head_err;
  logic [15:0] tail_oh;
  logic        tail_err;

  logic        push;
  logic        pop;
  logic        code_ok;
  logic [15:0] new_oh;
  logic        new_err;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Range check against the mode sampled alongside the code; sel=11 rejects everything.
  always_comb begin
    code_ok = 1'b0;
    case (sel)
      2'b00:   code_ok = (bin < 4'd8);
      2'b01:   code_ok = (bin < 4'd10);
      2'b10:   code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
    new_oh  = code_ok ? (16'b1 << bin) : 16'h0000;
    new_err = !code_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      head_oh  <= 16'h0000;
      head_err <= 1'b0;
      tail_oh  <= 16'h0000;
      tail_err <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_oh  <= new_oh;
            head_err <= new_err;
            count    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_oh  <= new_oh;
            head_err <= new_err;
          end else if (push) begin
            tail_oh  <= new_oh;
            tail_err <= new_err;
            count    <= 2'd2;
          end else if (pop) begin
            count    <= 2'd0;
          end
        end
        default: begin
          // Full: only a pop can happen, promoting the second entry.
          if (pop) begin
            head_oh  <= tail_oh;
            head_err <= tail_err;
            count    <= 2'd1;
          end
        end
      endcase
    end
  end

  assign onehot  = out_valid ? head_oh : 16'h0000;
  assign out_err = out_valid ? head_err : 1'b0;

`ifdef DEC_ERR_CNT_EN
  // Errors are counted when accepted, not when delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && new_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_binary_onehot_decoder.sv
// Directed self-checking bench for binary_onehot_decoder; err_cnt checks are compiled in with DEC_ERR_CNT_EN.
module tb_binary_onehot_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  bin;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] onehot;
  logic        out_err;
`ifdef DEC_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  binary_onehot_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .onehot    (onehot),
    .out_err   (out_err)
`ifdef DEC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = 4'h0; sel = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (onehot !== 16'h0000) begin errors++; $display("[TB] FAIL reset_onehot: got %h expected 0000", onehot); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
`ifdef DEC_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
  endtask

  task automatic test_hex_single();
    out_ready = 1'b1; in_valid = 1'b1; bin = 4'hF; sel = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hex_valid: got %b expected 1", out_valid); end
    checks++; if (onehot !== 16'h8000) begin errors++; $display("[TB] FAIL hex_onehot: got %h expected 8000", onehot); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL hex_err: got %b expected 0", out_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hex_valid_drop: got %b expected 0", out_valid); end
    checks++; if (onehot !== 16'h0000) begin errors++; $display("[TB] FAIL hex_onehot_idle: got %h expected 0000", onehot); end
  endtask

  task automatic test_range();
    logic [3:0]  codes [3];
    logic [1:0]  modes [3];
    logic [15:0] exp_oh [3];
    logic        exp_err [3];
    codes = '{4'd8, 4'd9, 4'd10};
    modes = '{2'b00, 2'b01, 2'b01};
    exp_oh = '{16'h0000, 16'h0200, 16'h0000};
    exp_err = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; bin = codes[i]; sel = modes[i];
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL range_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (onehot !== exp_oh[i]) begin errors++; $display("[TB] FAIL range_onehot[%0d]: got %h expected %h", i, onehot, exp_oh[i]); end
      checks++; if (out_err !== exp_err[i]) begin errors++; $display("[TB] FAIL range_err[%0d]: got %b expected %b", i, out_err, exp_err[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL range_drain: got %b expected 0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL range_err_idle: got %b expected 0", out_err); end
`ifdef DEC_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL range_err_cnt: got %0d expected 2", err_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'b10; bin = 4'd3;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b expected 1", in_ready); end
    checks++; if (onehot !== 16'h0008) begin errors++; $display("[TB] FAIL bp_head1: got %h expected 0008", onehot); end
    bin = 4'd5;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2: got %b expected 0", in_ready); end
    checks++; if (onehot !== 16'h0008) begin errors++; $display("[TB] FAIL bp_hold2: got %h expected 0008", onehot); end
    bin = 4'd7;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready3: got %b expected 0", in_ready); end
    checks++; if (onehot !== 16'h0008) begin errors++; $display("[TB] FAIL bp_hold3: got %h expected 0008", onehot); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid3: got %b expected 1", out_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (onehot !== 16'h0020) begin errors++; $display("[TB] FAIL bp_second: got %h expected 0020", onehot); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_release: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_release: got %b expected 1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b expected 0 (7 must not be queued)", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'b10;
    exp = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      bin = 4'(i);
      tick();
      checks++; if (onehot !== exp) begin errors++; $display("[TB] FAIL b2b_onehot[%0d]: got %h expected %h", i, onehot, exp); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_flow[%0d]: got valid=%b ready=%b expected 1/1", i, out_valid, in_ready); end
      exp = {exp[14:0], 1'b0};
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_disabled_saturate();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'b11;
    for (int i = 0; i < 300; i++) begin
      bin = 4'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || onehot !== 16'h0000 || out_err !== 1'b1) begin
        errors++; $display("[TB] FAIL dis_out[%0d]: got %b/%h/%b expected 1/0000/1", i, out_valid, onehot, out_err);
      end
`ifdef DEC_ERR_CNT_EN
      // Two errors were already counted, so 253 more reach 255.
      if (i == 251) begin
        checks++; if (err_cnt !== 8'd254) begin errors++; $display("[TB] FAIL dis_cnt_pre: got %0d expected 254", err_cnt); end
      end
`endif
    end
    in_valid = 1'b0;
    tick();
`ifdef DEC_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL dis_cnt_sat: got %0d expected 255", err_cnt); end
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dis_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'b10; bin = 4'd1;
    tick();
    bin = 4'd2;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_full: got %b expected 0", in_ready); end
    rst_n = 1'b0; bin = 4'd4; out_ready = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 1", in_ready); end
    checks++; if (onehot !== 16'h0000) begin errors++; $display("[TB] FAIL rmid_onehot: got %h expected 0000", onehot); end
`ifdef DEC_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rmid_err_cnt: got %0d expected 0", err_cnt); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_push: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_hex_single();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_disabled_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
